i2ctospi: RTL and testbench
===========================

I2CTOSPI -- requirements
Module: i2ctospi

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, 7-bit I2C address the block responds to.
REQ-002 SHALL have parameter SPI_DIV, default 4, number of clk cycles per spi_sclk half-period (legal values >= 2).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i2c_scl  input  1  I2C clock from an external master (asynchronous to clk).
REQ-006 i2c_sda_in  input  1  I2C data as sampled from the bus (asynchronous to clk).
REQ-007 i2c_sda_oe  output  1  1 = pull SDA low (open-drain ACK); 0 = release.
REQ-008 spi_sclk  output  1  SPI clock, mode 0, idle low.
REQ-009 spi_mosi  output  1  SPI serial data, MSB first.
REQ-010 spi_ss  output  1  SPI slave select, active low.
REQ-011 spi_done  output  1  one-clk pulse when a byte has been fully shifted out.
REQ-012 busy  output  1  high while the SPI shifter holds an unsent or in-flight byte.

Function
REQ-013 SHALL synchronize i2c_scl and i2c_sda_in through 2 flops each; edge detection SHALL use only synchronized values.
REQ-014 START = synchronized SDA falling while SCL high; STOP = SDA rising while SCL high.
REQ-015 I2C FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-016 START in any state -> ADDR with bit counter cleared (repeated START supported); STOP in any state -> IDLE with i2c_sda_oe = 0 in the same cycle.
REQ-017 ADDR/DATA: sample SDA on each SCL rising edge, MSB first, 8 bits.
REQ-018 After the 8th address bit: if bits[7:1] == SLAVE_ADDR and R/W bit == 0 -> ADDR_ACK; otherwise -> IGNORE (no ACK, SDA released until next START/STOP).
REQ-019 ACK: i2c_sda_oe SHALL assert on the SCL falling edge following the 8th bit and deassert on the next SCL falling edge; then ADDR_ACK -> DATA, DATA_ACK -> DATA.
REQ-020 After the 8th data bit: if busy == 0, load the byte into the SPI shifter and ACK; if busy == 1, drop the byte, do not ACK (NACK) and go to IGNORE.
REQ-021 Multiple data bytes per I2C transaction SHALL be accepted, each handled per REQ-020.
REQ-022 SPI side: on load, busy = 1 and spi_ss = 0 in the next clk; spi_mosi = byte[7] at the same time; first spi_sclk rise SPI_DIV clks later.
REQ-023 spi_sclk SHALL toggle every SPI_DIV clks; spi_mosi SHALL change only on spi_sclk falling edges (mode 0); 8 rising edges per byte.
REQ-024 After the 8th spi_sclk falling edge, spi_ss = 1, busy = 0 and spi_done = 1 for exactly one clk, all in the same cycle; spi_sclk SHALL remain low.
REQ-025 An I2C STOP or START SHALL NOT abort an in-progress SPI transfer.

Reset
REQ-026 While reset = 1: FSM = IDLE, i2c_sda_oe = 0, spi_sclk = 0, spi_mosi = 0, spi_ss = 1, spi_done = 0, busy = 0, counters and shift registers cleared.
REQ-027 Reset asserted mid-I2C or mid-SPI SHALL abort the transfer with no spi_done pulse; after release the block SHALL wait for a fresh START.

Configuration
REQ-028 Macro I2CTOSPI_OVERRUN_CNT_EN defined: adds output overrun_cnt [7:0], incremented on every byte dropped per REQ-020, saturating at 8'hFF, cleared by reset.
REQ-029 Macro not defined: no overrun_cnt port and no counter logic; all other behaviour identical.

Verification
REQ-030 START, addr 0x50 + W, data 0xA5, STOP -> ACK on both bytes; SPI shows MOSI 1,0,1,0,0,1,0,1 on 8 sclk rises; one spi_done pulse.
REQ-031 START, addr 0x51 + W, data 0x3C -> no ACK on address; spi_ss stays 1; no spi_done.
REQ-032 START, addr 0x50 + R -> no ACK; FSM in IGNORE until STOP; i2c_sda_oe = 0 throughout.
REQ-033 Two data bytes 0x11, 0x22 back-to-back with SPI_DIV = 64 -> 0x11 ACKed and sent; 0x22 NACKed and dropped; overrun_cnt = 1 when enabled.
REQ-034 Repeated START after address ACK, then addr 0x50 + W, data 0xFF -> ACKs; SPI sends 0xFF.
REQ-035 Reset asserted after 4 SPI sclk rises -> spi_ss = 1, spi_sclk = 0, busy = 0 next clk; no spi_done.

Source files
------------

// File: rtl/i2ctospi.sv
// I2C write-only slave that forwards each accepted data byte to a mode-0 SPI master.
// Optional overrun counter output is enabled by defining I2CTOSPI_OVERRUN_CNT_EN.
module i2ctospi #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         SPI_DIV    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    input  logic       i2c_sda_in,
    output logic       i2c_sda_oe,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic       spi_ss,
    output logic       spi_done,
    output logic       busy
`ifdef I2CTOSPI_OVERRUN_CNT_EN
    ,
    output logic [7:0] overrun_cnt
`endif
);

    localparam int DIV_W = (SPI_DIV > 2) ? $clog2(SPI_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPI_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } i2cState_t;

    i2cState_t        state_q;
    logic [1:0]       sclSync_q;
    logic [1:0]       sdaSync_q;
    logic             sclPrev_q;
    logic             sdaPrev_q;
    logic [2:0]       bitCnt_q;
    logic [6:0]       rxShift_q;
    logic             sdaOe_q;

    logic [7:0]       spiShift_q;
    logic [DIV_W-1:0] divCnt_q;
    logic [2:0]       spiBit_q;
    logic             sclk_q;
    logic             ss_q;
    logic             done_q;
    logic             busy_q;

    logic             sclS;
    logic             sdaS;
    logic             startDet;
    logic             stopDet;
    logic             sclRise;
    logic             sclFall;
    logic             byteDone;
    logic [7:0]       rxByte_d;
    logic             loadSpi;
    logic             dropByte;

    // Synchronizers reset to the idle bus level so release of reset creates no false edges
    always_ff @(posedge clk) begin
        if (reset) begin
            sclSync_q <= 2'b11;
            sdaSync_q <= 2'b11;
            sclPrev_q <= 1'b1;
            sdaPrev_q <= 1'b1;
        end else begin
            sclSync_q <= {sclSync_q[0], i2c_scl};
            sdaSync_q <= {sdaSync_q[0], i2c_sda_in};
            sclPrev_q <= sclSync_q[1];
            sdaPrev_q <= sdaSync_q[1];
        end
    end

    assign sclS     = sclSync_q[1];
    assign sdaS     = sdaSync_q[1];
    assign startDet = sclS & sclPrev_q & sdaPrev_q & ~sdaS;
    assign stopDet  = sclS & sclPrev_q & ~sdaPrev_q & sdaS;
    assign sclRise  = sclS & ~sclPrev_q;
    assign sclFall  = ~sclS & sclPrev_q;
    assign byteDone = sclRise && (bitCnt_q == 3'd7);
    assign rxByte_d = {rxShift_q, sdaS};
    assign loadSpi  = (state_q == DATA) && byteDone && !busy_q;
    assign dropByte = (state_q == DATA) && byteDone && busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bitCnt_q  <= 3'd0;
            rxShift_q <= 7'd0;
            sdaOe_q   <= 1'b0;
        end else if (stopDet) begin
            state_q <= IDLE;
            sdaOe_q <= 1'b0;
        end else if (startDet) begin
            state_q  <= ADDR;
            bitCnt_q <= 3'd0;
            sdaOe_q  <= 1'b0;
        end else begin
            case (state_q)
                ADDR, DATA: begin
                    if (sclRise) begin
                        rxShift_q <= rxByte_d[6:0];
                        bitCnt_q  <= bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            if (state_q == ADDR) begin
                                state_q <= (rxByte_d[7:1] == SLAVE_ADDR && !rxByte_d[0])
                                           ? ADDR_ACK : IGNORE;
                            end else begin
                                state_q <= busy_q ? IGNORE : DATA_ACK;
                            end
                        end
                    end
                end
                // First SCL fall after the byte drives ACK, the next one releases it
                ADDR_ACK, DATA_ACK: begin
                    if (sclFall) begin
                        if (!sdaOe_q) begin
                            sdaOe_q <= 1'b1;
                        end else begin
                            sdaOe_q  <= 1'b0;
                            state_q  <= DATA;
                            bitCnt_q <= 3'd0;
                        end
                    end
                end
                IGNORE: begin
                    sdaOe_q <= 1'b0;
                end
                default: begin
                    sdaOe_q <= 1'b0;
                end
            endcase
        end
    end

    // SPI shifter runs independently of the I2C FSM so bus START/STOP never aborts it
    always_ff @(posedge clk) begin
        if (reset) begin
            spiShift_q <= 8'd0;
            divCnt_q   <= '0;
            spiBit_q   <= 3'd0;
            sclk_q     <= 1'b0;
            ss_q       <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (loadSpi) begin
                spiShift_q <= rxByte_d;
                divCnt_q   <= '0;
                spiBit_q   <= 3'd0;
                sclk_q     <= 1'b0;
                ss_q       <= 1'b0;
                busy_q     <= 1'b1;
            end else if (busy_q) begin
                if (divCnt_q == DIV_LAST) begin
                    divCnt_q <= '0;
                    if (!sclk_q) begin
                        sclk_q <= 1'b1;
                    end else begin
                        sclk_q <= 1'b0;
                        if (spiBit_q == 3'd7) begin
                            ss_q   <= 1'b1;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            spiShift_q <= {spiShift_q[6:0], 1'b0};
                            spiBit_q   <= spiBit_q + 3'd1;
                        end
                    end
                end else begin
                    divCnt_q <= divCnt_q + DIV_W'(1);
                end
            end
        end
    end

`ifdef I2CTOSPI_OVERRUN_CNT_EN
    logic [7:0] overrun_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 8'd0;
        end else if (dropByte && overrun_q != 8'hFF) begin
            overrun_q <= overrun_q + 8'd1;
        end
    end

    assign overrun_cnt = overrun_q;
`else
    logic unusedDrop;
    assign unusedDrop = dropByte;
`endif

    assign i2c_sda_oe = sdaOe_q;
    assign spi_sclk   = sclk_q;
    assign spi_mosi   = spiShift_q[7];
    assign spi_ss     = ss_q;
    assign spi_done   = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2ctospi.sv
// Directed bench for i2ctospi: bit-banged I2C master, SPI monitor with byte scoreboard.
// Honours I2CTOSPI_OVERRUN_CNT_EN when the design is built with the overrun counter.
module tb_i2ctospi;

    localparam int SPI_DIV = 64;
    localparam int HALF    = 16;

    logic clk = 1'b0;
    logic reset;
    logic i2c_scl;
    logic masterSda;
    logic i2c_sda_in;
    logic i2c_sda_oe;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_ss;
    logic spi_done;
    logic busy;
`ifdef I2CTOSPI_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt;
`endif

    int assertCount = 0;
    int failCount   = 0;
    int doneCount   = 0;
    int riseCnt     = 0;
    int clkSinceLoad = 0;
    logic prevSclk  = 1'b0;
    logic prevBusy  = 1'b0;
    logic oeSeen    = 1'b0;
    logic ssLowSeen = 1'b0;
    logic [7:0] gotByte = 8'd0;
    logic [7:0] spiExpQ[$];

    always #5 clk = ~clk;

    // Open-drain bus: either side can pull SDA low
    assign i2c_sda_in = masterSda & ~i2c_sda_oe;

    i2ctospi #(.SLAVE_ADDR(7'h50), .SPI_DIV(SPI_DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .i2c_scl    (i2c_scl),
        .i2c_sda_in (i2c_sda_in),
        .i2c_sda_oe (i2c_sda_oe),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_ss     (spi_ss),
        .spi_done   (spi_done),
        .busy       (busy)
`ifdef I2CTOSPI_OVERRUN_CNT_EN
        ,
        .overrun_cnt(overrun_cnt)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2cStart();
        masterSda = 1'b1;
        i2c_scl   = 1'b1;
        waitClk(HALF);
        masterSda = 1'b0;
        waitClk(HALF);
        i2c_scl = 1'b0;
    endtask

    task automatic i2cRepStart();
        waitClk(HALF / 2);
        masterSda = 1'b1;
        waitClk(HALF / 2);
        i2c_scl = 1'b1;
        waitClk(HALF);
        masterSda = 1'b0;
        waitClk(HALF);
        i2c_scl = 1'b0;
    endtask

    task automatic i2cStop();
        waitClk(HALF / 2);
        masterSda = 1'b0;
        waitClk(HALF / 2);
        i2c_scl = 1'b1;
        waitClk(HALF);
        masterSda = 1'b1;
        waitClk(HALF);
    endtask

    // Clocks one byte out MSB first and samples the slave's ACK on the ninth clock
    task automatic applyStimulus(input logic [7:0] data, output logic acked);
        for (int i = 7; i >= 0; i--) begin
            waitClk(HALF / 2);
            masterSda = data[i];
            waitClk(HALF / 2);
            i2c_scl = 1'b1;
            waitClk(HALF);
            i2c_scl = 1'b0;
        end
        waitClk(HALF / 2);
        masterSda = 1'b1;
        waitClk(HALF / 2);
        i2c_scl = 1'b1;
        waitClk(HALF / 2);
        acked = ~i2c_sda_in;
        waitClk(HALF / 2);
        i2c_scl = 1'b0;
    endtask

    task automatic waitSpiIdle(input string tag);
        for (int n = 0; n < 3000; n++) begin
            waitClk(1);
            if (!busy) break;
        end
        checkOutput(tag, busy, 1'b0);
        waitClk(2);
    endtask

    // SPI monitor: assembles MOSI on sclk rises and scores each done pulse
    always @(negedge clk) begin
        if (i2c_sda_oe) oeSeen = 1'b1;
        if (!spi_ss) ssLowSeen = 1'b1;
        if (reset) begin
            riseCnt  = 0;
            prevSclk = 1'b0;
            prevBusy = 1'b0;
        end else begin
            if (busy && !prevBusy) begin
                clkSinceLoad = 0;
                checkOutput("load_ss_low", spi_ss, 1'b0);
                checkOutput("load_sclk_low", spi_sclk, 1'b0);
            end else if (busy) begin
                clkSinceLoad++;
            end
            if (spi_sclk && !prevSclk) begin
                if (riseCnt == 0) checkOutput("first_rise_delay", clkSinceLoad, SPI_DIV);
                gotByte = {gotByte[6:0], spi_mosi};
                riseCnt++;
            end
            if (spi_done) begin
                doneCount++;
                checkOutput("done_rises", riseCnt, 8);
                checkOutput("done_ss", spi_ss, 1'b1);
                checkOutput("done_busy", busy, 1'b0);
                checkOutput("done_sclk", spi_sclk, 1'b0);
                checkOutput("done_expected", spiExpQ.size() != 0, 1'b1);
                if (spiExpQ.size() != 0) checkOutput("spi_byte", gotByte, spiExpQ.pop_front());
                riseCnt = 0;
            end
            prevSclk = spi_sclk;
            prevBusy = busy;
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic ack;
        int doneBefore;
        reset     = 1'b1;
        i2c_scl   = 1'b1;
        masterSda = 1'b1;
        waitClk(4);
        checkOutput("rst_sda_oe", i2c_sda_oe, 1'b0);
        checkOutput("rst_sclk", spi_sclk, 1'b0);
        checkOutput("rst_mosi", spi_mosi, 1'b0);
        checkOutput("rst_ss", spi_ss, 1'b1);
        checkOutput("rst_done", spi_done, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        reset = 1'b0;
        waitClk(4);

        $display("[TB] basic write 0xA5");
        i2cStart();
        applyStimulus(8'hA0, ack);
        checkOutput("t1_addr_ack", ack, 1'b1);
        spiExpQ.push_back(8'hA5);
        applyStimulus(8'hA5, ack);
        checkOutput("t1_data_ack", ack, 1'b1);
        i2cStop();
        waitSpiIdle("t1_idle");
        checkOutput("t1_done_count", doneCount, 1);

        $display("[TB] wrong address 0x51");
        doneBefore = doneCount;
        ssLowSeen  = 1'b0;
        i2cStart();
        applyStimulus(8'hA2, ack);
        checkOutput("t2_addr_nack", ack, 1'b0);
        applyStimulus(8'h3C, ack);
        checkOutput("t2_data_nack", ack, 1'b0);
        i2cStop();
        waitClk(200);
        checkOutput("t2_ss_stayed_high", ssLowSeen, 1'b0);
        checkOutput("t2_no_done", doneCount, doneBefore);

        $display("[TB] read request ignored");
        oeSeen = 1'b0;
        i2cStart();
        applyStimulus(8'hA1, ack);
        checkOutput("t3_addr_nack", ack, 1'b0);
        applyStimulus(8'h00, ack);
        checkOutput("t3_ignore_nack", ack, 1'b0);
        i2cStop();
        checkOutput("t3_oe_never", oeSeen, 1'b0);

        $display("[TB] overrun 0x11 then 0x22");
        doneBefore = doneCount;
        i2cStart();
        applyStimulus(8'hA0, ack);
        checkOutput("t4_addr_ack", ack, 1'b1);
        spiExpQ.push_back(8'h11);
        applyStimulus(8'h11, ack);
        checkOutput("t4_first_ack", ack, 1'b1);
        applyStimulus(8'h22, ack);
        checkOutput("t4_second_nack", ack, 1'b0);
        i2cStop();
`ifdef I2CTOSPI_OVERRUN_CNT_EN
        checkOutput("t4_overrun", overrun_cnt, 8'd1);
`endif
        waitSpiIdle("t4_idle");
        checkOutput("t4_done_count", doneCount, doneBefore + 1);

        $display("[TB] repeated start then 0xFF");
        doneBefore = doneCount;
        i2cStart();
        applyStimulus(8'hA0, ack);
        checkOutput("t5_addr1_ack", ack, 1'b1);
        i2cRepStart();
        applyStimulus(8'hA0, ack);
        checkOutput("t5_addr2_ack", ack, 1'b1);
        spiExpQ.push_back(8'hFF);
        applyStimulus(8'hFF, ack);
        checkOutput("t5_data_ack", ack, 1'b1);
        i2cStop();
        waitSpiIdle("t5_idle");
        checkOutput("t5_done_count", doneCount, doneBefore + 1);

        $display("[TB] reset mid SPI transfer");
        doneBefore = doneCount;
        i2cStart();
        applyStimulus(8'hA0, ack);
        checkOutput("t6_addr_ack", ack, 1'b1);
        spiExpQ.push_back(8'h5A);
        applyStimulus(8'h5A, ack);
        checkOutput("t6_data_ack", ack, 1'b1);
        for (int n = 0; n < 3000; n++) begin
            if (riseCnt >= 4) break;
            waitClk(1);
        end
        checkOutput("t6_rises_reached", riseCnt, 4);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t6_rst_ss", spi_ss, 1'b1);
        checkOutput("t6_rst_sclk", spi_sclk, 1'b0);
        checkOutput("t6_rst_busy", busy, 1'b0);
        checkOutput("t6_rst_done", spi_done, 1'b0);
        reset = 1'b0;
        spiExpQ.delete();
        applyStimulus(8'hA0, ack);
        checkOutput("t6_no_ack_without_start", ack, 1'b0);
        i2cStop();
        waitClk(1200);
        checkOutput("t6_no_done", doneCount, doneBefore);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
